// File: rtl/keccak_pkg.sv
// Shared Keccak types and constants used by the squeeze output unit.
package keccak_pkg;

    localparam int LANE_W  = 64;
    localparam int STATE_W = 1600;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_STATE = 2'd1,
        EMIT       = 2'd2,
        PERM       = 2'd3
    } sq_state_t;

endpackage

// File: rtl/keccak_squeeze_out.sv
// Squeeze-phase output unit: buffers the rate part of a permuted state and
// streams it as 64-bit lanes, requesting further permutations as needed.
module keccak_squeeze_out
    import keccak_pkg::*;
#(
    parameter int RATE_WORDS = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         len_words,
    input  logic [STATE_W-1:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               perm_req,
    output logic [LANE_W-1:0]  m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    localparam int BUF_W = LANE_W * RATE_WORDS;
    localparam logic [4:0] LAST_IDX = 5'(RATE_WORDS - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never drops and data never changes until then.

    sq_state_t         state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [7:0]        rem_q, rem_d;
    logic [4:0]        idx_q, idx_d;
    logic              done_d;

    logic              s_ready_q, m_valid_q, m_last_q, perm_req_q, busy_q, done_q;
    logic [LANE_W-1:0] m_data_q;

    // Capacity lanes never reach the output.
    logic unused_capacity;
    assign unused_capacity = ^s_data[STATE_W-1:BUF_W];

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (len_words != 8'd0)) begin
                    rem_d   = len_words;
                    state_d = WAIT_STATE;
                end
            end
            WAIT_STATE: begin
                if (s_valid && s_ready_q) begin
                    buf_d   = s_data[BUF_W-1:0];
                    idx_d   = 5'd0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (m_valid_q && m_ready) begin
                    buf_d = buf_q >> LANE_W;
                    rem_d = rem_q - 8'd1;
                    idx_d = idx_q + 5'd1;
                    if (rem_q == 8'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = PERM;
                    end
                end
            end
            PERM: begin
                state_d = WAIT_STATE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            rem_q      <= 8'd0;
            idx_q      <= 5'd0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            perm_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            m_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            s_ready_q  <= (state_d == WAIT_STATE);
            m_valid_q  <= (state_d == EMIT);
            m_last_q   <= (state_d == EMIT) && (rem_d == 8'd1);
            perm_req_q <= (state_d == PERM);
            busy_q     <= (state_d != IDLE);
            done_q     <= done_d;
            m_data_q   <= (state_d == EMIT) ? buf_d[LANE_W-1:0] : '0;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign perm_req  = perm_req_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign m_data    = m_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_keccak_squeeze_out.sv
// Directed bench for keccak_squeeze_out with RATE_WORDS = 17.
module tb_keccak_squeeze_out;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [7:0]    len_words;
    logic [1599:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          perm_req;
    logic [63:0]   m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int perm_cnt = 0;

    keccak_squeeze_out #(.RATE_WORDS(17)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len_words (len_words),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .perm_req  (perm_req),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (perm_req) perm_cnt++;

    function automatic logic [1599:0] make_state(input logic [63:0] base);
        logic [1599:0] st;
        st = '0;
        for (int k = 0; k < 25; k++) st[64*k +: 64] = base + 64'(k);
        return st;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sq(input logic [7:0] n);
        start = 1'b1;
        len_words = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_state(input logic [1599:0] st);
        s_data = st;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len_words = 8'd0; s_data = '0;
        s_valid = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b want 0", m_last); end
        checks++; if (perm_req !== 1'b0) begin errors++; $display("FAIL reset_perm_req got %b want 0", perm_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (m_data !== 64'd0) begin errors++; $display("FAIL reset_m_data got %h want 0", m_data); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_block();
        int p0;
        p0 = perm_cnt;
        m_ready = 1'b1;
        start_sq(8'd4);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL single_s_ready got %b want 1", s_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        send_state(make_state(64'd1));
        for (int i = 0; i < 4; i++) begin
            checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_m_valid lane %0d got %b want 1", i, m_valid); end
            checks++; if (m_data !== 64'(i + 1)) begin errors++; $display("FAIL single_m_data lane %0d got %h want %h", i, m_data, i + 1); end
            checks++; if (m_last !== (i == 3)) begin errors++; $display("FAIL single_m_last lane %0d got %b want %b", i, m_last, i == 3); end
            tick();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_m_valid_end got %b want 0", m_valid); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b want 0", done); end
        checks++; if (perm_cnt != p0) begin errors++; $display("FAIL single_perm got %0d want %0d", perm_cnt, p0); end
    endtask

    task automatic test_multi_block();
        int p0;
        p0 = perm_cnt;
        m_ready = 1'b1;
        start_sq(8'd20);
        send_state(make_state(64'd1));
        for (int i = 0; i < 17; i++) begin
            checks++; if (m_valid !== 1'b1 || m_data !== 64'(i + 1) || m_last !== 1'b0) begin
                errors++; $display("FAIL multi_lane %0d got v=%b d=%h l=%b want v=1 d=%h l=0", i, m_valid, m_data, m_last, i + 1);
            end
            tick();
        end
        checks++; if (perm_req !== 1'b1) begin errors++; $display("FAIL multi_perm_req got %b want 1", perm_req); end
        checks++; if (s_ready !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL multi_perm_idle got s_ready=%b m_valid=%b want 0 0", s_ready, m_valid); end
        tick();
        checks++; if (perm_req !== 1'b0) begin errors++; $display("FAIL multi_perm_pulse got %b want 0", perm_req); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL multi_s_ready got %b want 1", s_ready); end
        send_state(make_state(64'h100));
        for (int i = 0; i < 3; i++) begin
            checks++; if (m_valid !== 1'b1 || m_data !== 64'h100 + 64'(i) || m_last !== (i == 2)) begin
                errors++; $display("FAIL multi_lane2 %0d got v=%b d=%h l=%b want v=1 d=%h l=%b", i, m_valid, m_data, m_last, 64'h100 + 64'(i), i == 2);
            end
            tick();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL multi_done got %b want 1", done); end
        checks++; if (perm_cnt != p0 + 1) begin errors++; $display("FAIL multi_perm_count got %0d want %0d", perm_cnt - p0, 1); end
        tick();
    endtask

    task automatic test_backpressure();
        int hs;
        hs = 0;
        m_ready = 1'b0;
        start_sq(8'd3);
        send_state(make_state(64'd1));
        for (int c = 0; c < 12 && hs < 3; c++) begin
            m_ready = ((c % 3) == 0);
            checks++; if (m_valid !== 1'b1 || m_data !== 64'(hs + 1) || m_last !== (hs == 2)) begin
                errors++; $display("FAIL bp_cycle %0d got v=%b d=%h l=%b want v=1 d=%h l=%b", c, m_valid, m_data, m_last, hs + 1, hs == 2);
            end
            if (m_valid && m_ready) hs++;
            tick();
        end
        checks++; if (hs != 3) begin errors++; $display("FAIL bp_handshakes got %0d want 3", hs); end
        checks++; if (done !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL bp_done got done=%b m_valid=%b want 1 0", done, m_valid); end
        m_ready = 1'b1;
        tick();
    endtask

    task automatic test_exact_multiple();
        int p0;
        p0 = perm_cnt;
        m_ready = 1'b1;
        start_sq(8'd17);
        send_state(make_state(64'd1));
        for (int i = 0; i < 17; i++) begin
            checks++; if (m_valid !== 1'b1 || m_data !== 64'(i + 1) || m_last !== (i == 16)) begin
                errors++; $display("FAIL exact_lane %0d got v=%b d=%h l=%b want v=1 d=%h l=%b", i, m_valid, m_data, m_last, i + 1, i == 16);
            end
            tick();
        end
        checks++; if (done !== 1'b1 || perm_req !== 1'b0) begin errors++; $display("FAIL exact_done got done=%b perm_req=%b want 1 0", done, perm_req); end
        tick();
        tick();
        checks++; if (s_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL exact_idle got s_ready=%b busy=%b want 0 0", s_ready, busy); end
        checks++; if (perm_cnt != p0) begin errors++; $display("FAIL exact_perm got %0d want 0", perm_cnt - p0); end
    endtask

    task automatic test_ignored();
        start = 1'b1;
        len_words = 8'd0;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL ign_len0 got busy=%b s_ready=%b want 0 0", busy, s_ready); end
        s_data = make_state(64'h55);
        s_valid = 1'b1;
        tick();
        tick();
        s_valid = 1'b0;
        checks++; if (s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL ign_svalid got s_ready=%b m_valid=%b busy=%b want 0 0 0", s_ready, m_valid, busy);
        end
        m_ready = 1'b0;
        start_sq(8'd2);
        send_state(make_state(64'd1));
        start = 1'b1;
        len_words = 8'd100;
        tick();
        start = 1'b0;
        checks++; if (m_valid !== 1'b1 || m_data !== 64'd1 || m_last !== 1'b0) begin
            errors++; $display("FAIL ign_start got v=%b d=%h l=%b want v=1 d=1 l=0", m_valid, m_data, m_last);
        end
        m_ready = 1'b1;
        tick();
        checks++; if (m_valid !== 1'b1 || m_data !== 64'd2 || m_last !== 1'b1) begin
            errors++; $display("FAIL ign_lane2 got v=%b d=%h l=%b want v=1 d=2 l=1", m_valid, m_data, m_last);
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done got %b want 1", done); end
        tick();
        checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL ign_idle got busy=%b s_ready=%b want 0 0", busy, s_ready); end
    endtask

    task automatic test_reset_mid_emit();
        m_ready = 1'b1;
        start_sq(8'd4);
        send_state(make_state(64'd1));
        checks++; if (m_data !== 64'd1) begin errors++; $display("FAIL rst_lane1 got %h want 1", m_data); end
        tick();
        checks++; if (m_data !== 64'd2) begin errors++; $display("FAIL rst_lane2 got %h want 2", m_data); end
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || m_data !== 64'd0 || m_last !== 1'b0) begin
            errors++; $display("FAIL rst_async_m got v=%b d=%h l=%b want 0 0 0", m_valid, m_data, m_last);
        end
        checks++; if (busy !== 1'b0 || s_ready !== 1'b0 || perm_req !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_async_ctl got busy=%b s_ready=%b perm_req=%b done=%b want 0", busy, s_ready, perm_req, done);
        end
        #2;
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || m_valid !== 1'b0 || dbg_state !== 2'd0) begin
            errors++; $display("FAIL rst_release got busy=%b m_valid=%b state=%0d want 0 0 0", busy, m_valid, dbg_state);
        end
        start_sq(8'd1);
        send_state(make_state(64'hA0));
        checks++; if (m_valid !== 1'b1 || m_data !== 64'hA0 || m_last !== 1'b1) begin
            errors++; $display("FAIL rst_new got v=%b d=%h l=%b want v=1 d=a0 l=1", m_valid, m_data, m_last);
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_new_done got %b want 1", done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_multi_block();
        test_backpressure();
        test_exact_multiple();
        test_ignored();
        test_reset_mid_emit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keccak_squeeze_out.md
# keccak_squeeze_out

Squeeze-phase output unit of the Keccak core. It consumes the 1600-bit state string produced after the permutation. It buffers the rate portion and streams it out as 64-bit lanes over a valid/ready interface, for a caller-selected number of lanes. When the requested length exceeds one rate block, as in SHAKE, it requests a further permutation and accepts the next state.

## Interface
- RATE_WORDS, 17: rate in 64-bit lanes.
  - Legal range 1..24.
  - 17 = SHA3-256 (1088 bits); 21 = SHAKE128.
- LANE_W, 64: output word width. Fixed by the Keccak-f[1600] lane size.

One clock; reset is asynchronous and active-low.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a squeeze. `len_words` is sampled on the same cycle.
- len_words  in  8  total number of lanes to emit (1..255).
- s_data  in  1600  state string. Lane k = s_data[64k+63:64k].
- s_valid  in  1  s_data valid.
- s_ready  out  1  block accepts a state string.
- perm_req  out  1  one-cycle pulse: permute the current state and return it on s_data.
- m_data  out  64  output lane.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts m_data.
- m_last  out  1  qualifies the final lane of the squeeze.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final lane handshake.

## Operation
- FSM has four states: IDLE, WAIT_STATE, EMIT, PERM.
- **IDLE**
  - `start` with `len_words` != 0: load `remaining` = `len_words` and go to WAIT_STATE.
  - `start` with `len_words` = 0 is ignored.
- **WAIT_STATE**
  - `s_ready` = 1.
  - On `s_valid` & `s_ready`:
    - load the shift buffer with s_data[64*RATE_WORDS-1:0]; the capacity bits are discarded;
    - load `lane_idx` = 0;
    - go to EMIT.
- **EMIT**
  - `m_valid` = 1 and `m_data` = buffer[63:0].
  - `m_last` = (`remaining` == 1).
  - On `m_valid` & `m_ready`:
    - shift the buffer right by 64;
    - decrement `remaining`;
    - increment `lane_idx`.
  - After that handshake:
    - if `remaining` was 1, go to IDLE and pulse `done`;
    - else if `lane_idx` was RATE_WORDS-1, go to PERM;
    - else stay in EMIT.
- **PERM**
  - `perm_req` = 1 for exactly this one cycle, then go to WAIT_STATE.
- `start` outside IDLE is ignored.
- `s_valid` outside WAIT_STATE is ignored: no capture, and `s_ready` stays 0.
- Lane byte order is passed through unchanged; output is little-endian per Keccak convention.

## Timing
- Every output is registered.
- Reset values:
  - FSM = IDLE;
  - `s_ready`, `m_valid`, `m_last`, `perm_req`, `busy`, `done` = 0;
  - `m_data` = 0; buffer, `remaining`, `lane_idx` = 0.
- From `start` to `s_ready` high: 1 cycle.
- From s-handshake to `m_valid` high with lane 0: 1 cycle.
- Throughput is 1 lane per cycle while `m_ready` is held high.
- Once `m_valid` is asserted, `m_data` and `m_last` hold stable until the handshake. `m_valid` never drops without a handshake.
- End of squeeze: `done` pulses in the cycle after the last handshake. `busy` falls in that same cycle. A new `start` is accepted in that cycle.
- Rate-block boundary: after the RATE_WORDS-th lane handshake, PERM lasts 1 cycle (`perm_req` high). `s_ready` is high in the following cycle.
- `len_words` equal to an exact multiple of RATE_WORDS finishes with `done`; no `perm_req` is issued.
- `rst_n` low at any point, including mid-EMIT or PERM, forces all reset values immediately. Nothing is emitted afterwards until a new `start`.

## Structure
- `keccak_pkg` gains:
  - `LANE_W` = 64;
  - `STATE_W` = 1600;
  - `sq_state_t` enum {IDLE, WAIT_STATE, EMIT, PERM}.
- The block is compatible with the existing `plane`/`state` types through the 1600-bit string.
- No sub-module. The 64*RATE_WORDS shift buffer, 8-bit `remaining` counter and 5-bit `lane_idx` counter live inline.

## Test plan
- **SHA3-256 single block.**
  - Stimulus: RATE_WORDS=17, `len_words`=4, lane k = k+1, `m_ready`=1.
  - Response: `m_data` = 1, 2, 3, 4 on consecutive cycles; `m_last` on 4; `done` 1 cycle later; `perm_req` never asserted.
- **Multi-block.**
  - Stimulus: `len_words`=20, first state lanes k+1, second state lanes 0x100+k.
  - Response: lanes 1..17, then one `perm_req` pulse, then `s_ready`; after the second state, 0x100, 0x101, 0x102 with `m_last` on 0x102.
- **Backpressure.**
  - Stimulus: `len_words`=3, `m_ready` toggling 1,0,0,1,...
  - Response: `m_data` and `m_last` stable while stalled; exactly 3 handshakes; order 1, 2, 3.
- **Exact multiple.**
  - Stimulus: `len_words`=17.
  - Response: 17 lanes, `m_last` on lane 17, `done`, no `perm_req`.
- **Ignored requests.**
  - Stimulus: `start` with `len_words`=0; `start` while in EMIT; `s_valid` while in IDLE.
  - Response: no state change and no extra output.
- **Async reset mid-EMIT.**
  - Stimulus: assert `rst_n`=0 after lane 2 of 4.
  - Response: all outputs 0 immediately; IDLE after release; a new `start` with `len_words`=1 yields lane 1 from the new state.
